// File: rtl/isw_dup_checker.sv
// Comparator for the duplicated first-order ISW multiplier: aligns both redundant share results with a delayed valid, forwards only agreeing results, and escalates mismatches into a sticky alarm.
// Optional counter/threshold escalation is enabled by defining ISW_DUP_CHECKER_CNT_EN.
module isw_dup_checker #(
  parameter int SHARES    = 2,
  parameter int LATENCY   = 3,
  parameter int CNT_W     = 8,
  parameter int THRESHOLD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SHARES-1:0] res_a,
  input  logic [SHARES-1:0] res_b,
  input  logic              clear_alarm,
  output logic              out_valid,
  output logic [SHARES-1:0] out_res,
  output logic              out_fault,
  output logic              alarm,
  output logic [CNT_W-1:0]  fault_cnt
);

  typedef enum logic {RUN, ALARM} state_t;

  state_t             state;
  logic [LATENCY-1:0] valid_sr;
  logic               v_al;
  logic               eq;
  logic               mismatch;
  logic               trip;

  assign v_al     = valid_sr[LATENCY-1];
  // Share-wise comparison only; shares are never recombined into a clear value.
  assign eq       = &(res_a ~^ res_b);
  assign mismatch = v_al & ~eq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
      end
    end
  end

`ifdef ISW_DUP_CHECKER_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (fault_cnt == CNT_MAX) ? fault_cnt : fault_cnt + 1'b1;
  assign trip    = (cnt_inc >= THR);

  // A clear wins over a same-cycle mismatch so software always restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_cnt <= '0;
    end else if ((state == ALARM) && clear_alarm) begin
      fault_cnt <= '0;
    end else if (mismatch) begin
      fault_cnt <= cnt_inc;
    end
  end
`else
  assign trip      = 1'b1;
  assign fault_cnt = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      alarm     <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_fault <= 1'b0;
    end else begin
      out_fault <= mismatch;
      out_valid <= 1'b0;
      out_res   <= '0;
      case (state)
        RUN: begin
          if (v_al && eq) begin
            out_valid <= 1'b1;
            out_res   <= res_a;
          end else if (mismatch && trip) begin
            state <= ALARM;
            alarm <= 1'b1;
          end
        end
        ALARM: begin
          if (clear_alarm) begin
            state <= RUN;
            alarm <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isw_dup_checker.sv
// Randomized and directed self-checking bench for isw_dup_checker against a cycle-indexed behavioural model.
module tb_isw_dup_checker;

  localparam int SHARES = 2;
  localparam int LAT    = 3;
  localparam int CNT_W  = 3;
  localparam int THR    = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int DEPTH  = 8192;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [SHARES-1:0] res_a = '0;
  logic [SHARES-1:0] res_b = '0;
  logic              clear_alarm = 1'b0;
  logic              out_valid;
  logic [SHARES-1:0] out_res;
  logic              out_fault;
  logic              alarm;
  logic [CNT_W-1:0]  fault_cnt;

  isw_dup_checker #(
    .SHARES(SHARES), .LATENCY(LAT), .CNT_W(CNT_W), .THRESHOLD(THR)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .res_a(res_a), .res_b(res_b),
    .clear_alarm(clear_alarm), .out_valid(out_valid), .out_res(out_res),
    .out_fault(out_fault), .alarm(alarm), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_cyc = 0;
  bit hist [DEPTH];
  logic [SHARES-1:0] sa [DEPTH];
  logic [SHARES-1:0] sb [DEPTH];

  bit m_alarm = 1'b0;
  int m_cnt = 0;
  bit e_valid, e_fault;
  logic [SHARES-1:0] e_res;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic checkModel();
    checkOutput("m_valid", 32'(out_valid), 32'(e_valid));
    checkOutput("m_res", 32'(out_res), 32'(e_res));
    checkOutput("m_fault", 32'(out_fault), 32'(e_fault));
    checkOutput("m_alarm", 32'(alarm), 32'(m_alarm));
    checkOutput("m_cnt", 32'(fault_cnt), 32'(m_cnt));
  endtask

  // Results for an op issued in cycle c are presented in cycle c+LAT; the model
  // decides from the in_valid history whether that cycle carries a live result.
  task automatic applyStimulus(input bit iv, input logic [SHARES-1:0] a, input logic [SHARES-1:0] b,
                               input bit clr);
    bit live, mm;
    if (iv) begin
      sa[cyc+LAT] = a;
      sb[cyc+LAT] = b;
    end
    in_valid    = iv;
    res_a       = sa[cyc];
    res_b       = sb[cyc];
    clear_alarm = clr;
    hist[cyc]   = iv;
    live = 1'b0;
    if (cyc - LAT >= first_cyc) live = hist[cyc-LAT];
    mm      = live && (sa[cyc] != sb[cyc]);
    e_fault = mm;
    e_valid = live && (sa[cyc] == sb[cyc]) && !m_alarm;
    e_res   = e_valid ? sa[cyc] : '0;
    if (!m_alarm) begin
      if (mm) begin
`ifdef ISW_DUP_CHECKER_CNT_EN
        if (m_cnt < CMAX) m_cnt++;
        if (m_cnt >= THR) m_alarm = 1'b1;
`else
        m_alarm = 1'b1;
`endif
      end
    end else if (clr) begin
      m_alarm = 1'b0;
      m_cnt   = 0;
    end else if (mm) begin
`ifdef ISW_DUP_CHECKER_CNT_EN
      if (m_cnt < CMAX) m_cnt++;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checkModel();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    clear_alarm = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_res", 32'(out_res), 32'd0);
    checkOutput("rst_fault", 32'(out_fault), 32'd0);
    checkOutput("rst_alarm", 32'(alarm), 32'd0);
    checkOutput("rst_cnt", 32'(fault_cnt), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
    reset     = 1'b0;
    first_cyc = cyc;
    m_alarm   = 1'b0;
    m_cnt     = 0;
  endtask

  initial begin
    logic [SHARES-1:0] vals [4];
    bit iv, clr;
    logic [SHARES-1:0] a, b;

    for (int i = 0; i < DEPTH; i++) begin
      sa[i] = SHARES'($urandom);
      sb[i] = SHARES'($urandom);
      hist[i] = 1'b0;
    end
    @(negedge clk);
    doReset(2);

    // Single op, equal copies.
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    idle(3);
    checkOutput("tp1_valid", 32'(out_valid), 32'd1);
    checkOutput("tp1_res", 32'(out_res), 32'h2);
    checkOutput("tp1_alarm", 32'(alarm), 32'd0);
    checkOutput("tp1_cnt", 32'(fault_cnt), 32'd0);

    // Back-to-back ops.
    vals[0] = 2'b00; vals[1] = 2'b01; vals[2] = 2'b11; vals[3] = 2'b10;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, vals[i], vals[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(1);
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_res", 32'(out_res), 32'(vals[i]));
      checkOutput("b2b_fault", 32'(out_fault), 32'd0);
    end

    // Mismatches escalating to alarm.
    applyStimulus(1'b1, 2'b01, 2'b11, 1'b0);
    applyStimulus(1'b1, 2'b01, 2'b11, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    idle(1);
    checkOutput("mm1_fault", 32'(out_fault), 32'd1);
    checkOutput("mm1_valid", 32'(out_valid), 32'd0);
`ifdef ISW_DUP_CHECKER_CNT_EN
    checkOutput("mm1_cnt", 32'(fault_cnt), 32'd1);
    checkOutput("mm1_alarm", 32'(alarm), 32'd0);
`else
    checkOutput("mm1_cnt", 32'(fault_cnt), 32'd0);
    checkOutput("mm1_alarm", 32'(alarm), 32'd1);
`endif
    idle(1);
    checkOutput("mm2_fault", 32'(out_fault), 32'd1);
    checkOutput("mm2_alarm", 32'(alarm), 32'd1);
`ifdef ISW_DUP_CHECKER_CNT_EN
    checkOutput("mm2_cnt", 32'(fault_cnt), 32'd2);
`else
    checkOutput("mm2_cnt", 32'(fault_cnt), 32'd0);
`endif
    idle(1);
    checkOutput("alarm_blk_valid", 32'(out_valid), 32'd0);
    checkOutput("alarm_blk_res", 32'(out_res), 32'd0);

    // Counter saturation while held in alarm.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'b00, 2'b01, 1'b0);
    idle(3);
    checkOutput("sat_alarm", 32'(alarm), 32'd1);
`ifdef ISW_DUP_CHECKER_CNT_EN
    checkOutput("sat_cnt", 32'(fault_cnt), 32'(CMAX));
`else
    checkOutput("sat_cnt", 32'(fault_cnt), 32'd0);
`endif

    // Clear coinciding with an aligned mismatch.
    applyStimulus(1'b1, 2'b10, 2'b00, 1'b0);
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("clr_fault", 32'(out_fault), 32'd1);
    checkOutput("clr_alarm", 32'(alarm), 32'd0);
    checkOutput("clr_cnt", 32'(fault_cnt), 32'd0);
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b0);
    idle(3);
    checkOutput("post_clr_valid", 32'(out_valid), 32'd1);
    checkOutput("post_clr_res", 32'(out_res), 32'h3);

    // Reset with two ops in flight.
    applyStimulus(1'b1, 2'b01, 2'b01, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b10, 1'b0);
    doReset(2);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("flush_valid", 32'(out_valid), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      iv  = ($urandom_range(0, 9) < 7);
      a   = SHARES'($urandom);
      b   = ($urandom_range(0, 9) < 8) ? a : SHARES'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      applyStimulus(iv, a, b, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
